// File: rtl/mmio_timer_pkg.sv
// Shared types and constants for the memory-mapped interval timer.
package timer_pkg;

   typedef enum logic [1:0] {
      STOPPED = 2'd0,
      RUNNING = 2'd1,
      EXPIRED = 2'd2
   } timer_state_t;

   // Word offsets (Address[4:2]) inside the 32-byte window
   localparam logic [2:0] OFF_CTRL    = 3'd0;
   localparam logic [2:0] OFF_COUNT   = 3'd1;
   localparam logic [2:0] OFF_COMPARE = 3'd2;
   localparam logic [2:0] OFF_STATUS  = 3'd3;
   localparam logic [2:0] OFF_PRESC   = 3'd4;

   localparam int CTRL_ENABLE      = 0;
   localparam int CTRL_IRQ_EN      = 1;
   localparam int CTRL_AUTO_RELOAD = 2;

   localparam logic [31:0] COMPARE_RST = 32'hFFFF_FFFF;

   function automatic logic in_window(input logic [31:0] addr, input logic [31:0] base);
      return addr[31:5] == base[31:5];
   endfunction

endpackage

// File: rtl/mmio_timer_if.sv
// CPU memory-bus view of the timer plus its interrupt request/acknowledge pair.
interface mmio_timer_if;
   logic [31:0] Address;
   logic        wr;
   logic [31:0] WriteData;
   logic [31:0] ReadData;
   logic        hit;
   logic        irq;
   logic        irq_ack;

   modport master (
      output Address, wr, WriteData, irq_ack,
      input  ReadData, hit, irq
   );

   modport slave (
      input  Address, wr, WriteData, irq_ack,
      output ReadData, hit, irq
   );
endinterface

// File: rtl/mmio_timer_prescaler.sv
// Prescaler: counts 0..presc while run is high and emits tick on the terminal count.
module timer_prescaler #(
   parameter int PRESC_W = 16
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               run,
   input  logic [PRESC_W-1:0] presc,
   output logic               tick
);
   logic [PRESC_W-1:0] cnt_reg, cnt_next;

   // >= rather than == so lowering PRESC mid-count cannot strand the counter above it
   assign tick = run && (cnt_reg >= presc);

   always_comb begin
      cnt_next = cnt_reg;
      if (!run || tick) begin
         cnt_next = '0;
      end else begin
         cnt_next = cnt_reg + PRESC_W'(1);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt_reg <= '0;
      end else begin
         cnt_reg <= cnt_next;
      end
   end
endmodule

// File: rtl/mmio_timer.sv
// Memory-mapped interval timer with prescaler, compare match and level irq.
// Optional feature: define TIMER_AUTORELOAD_EN to implement CTRL.auto_reload.
module mmio_timer
   import timer_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0400,
   parameter int          PRESC_W   = 16
) (
   input logic         clock,
   input logic         reset,
   mmio_timer_if.slave bus
);
   timer_state_t       state_reg, state_next;
   logic [2:0]         ctrl_reg, ctrl_wr;
   logic [31:0]        count_reg, count_next, compare_reg;
   logic [PRESC_W-1:0] presc_reg;
   logic               pending_reg, hit_reg;
   logic [31:0]        read_data_reg, read_mux;

   logic       in_win, store;
   logic [2:0] offset;
   logic       st_ctrl, st_count, st_compare, st_status, st_presc;
   logic       en_eff, auto_reload, run, tick;
   logic       count_inc, count_clr, set_pending, clr_pending;
   logic       unused_addr_bits;

   assign in_win     = in_window(bus.Address, BASE_ADDR);
   assign offset     = bus.Address[4:2];
   assign store      = in_win && bus.wr;
   assign st_ctrl    = store && (offset == OFF_CTRL);
   assign st_count   = store && (offset == OFF_COUNT);
   assign st_compare = store && (offset == OFF_COMPARE);
   assign st_status  = store && (offset == OFF_STATUS);
   assign st_presc   = store && (offset == OFF_PRESC);
   assign unused_addr_bits = ^bus.Address[1:0];

`ifdef TIMER_AUTORELOAD_EN
   assign ctrl_wr = bus.WriteData[2:0];
`else
   assign ctrl_wr = {1'b0, bus.WriteData[1:0]};
`endif

   // A CTRL store takes effect on the FSM in the same cycle it is written
   assign en_eff      = st_ctrl ? bus.WriteData[CTRL_ENABLE] : ctrl_reg[CTRL_ENABLE];
   assign auto_reload = ctrl_reg[CTRL_AUTO_RELOAD];
   assign run         = (state_reg == RUNNING);
   assign clr_pending = bus.irq_ack || (st_status && bus.WriteData[0]);

   timer_prescaler #(.PRESC_W(PRESC_W)) u_presc (
      .clock (clock),
      .reset (reset),
      .run   (run),
      .presc (presc_reg),
      .tick  (tick)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_reg <= STOPPED;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         STOPPED: if (en_eff) state_next = RUNNING;
         RUNNING: begin
            if (!en_eff) begin
               state_next = STOPPED;
            end else if (set_pending && !auto_reload) begin
               state_next = EXPIRED;
            end
         end
         EXPIRED: if (st_ctrl) state_next = bus.WriteData[CTRL_ENABLE] ? RUNNING : STOPPED;
         default: state_next = STOPPED;
      endcase
   end

   always_comb begin
      count_inc   = 1'b0;
      count_clr   = 1'b0;
      set_pending = 1'b0;
      if ((state_reg == RUNNING) && tick) begin
         if (count_reg == compare_reg) begin
            set_pending = 1'b1;
            count_clr   = auto_reload;
         end else begin
            count_inc = 1'b1;
         end
      end
   end

   always_comb begin
      count_next = count_reg;
      if (st_count) begin
         count_next = bus.WriteData;
      end else if (count_clr) begin
         count_next = '0;
      end else if (count_inc) begin
         count_next = count_reg + 32'd1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ctrl_reg    <= '0;
         count_reg   <= '0;
         compare_reg <= COMPARE_RST;
         presc_reg   <= '0;
         pending_reg <= 1'b0;
      end else begin
         count_reg <= count_next;
         if (st_ctrl)    ctrl_reg    <= ctrl_wr;
         if (st_compare) compare_reg <= bus.WriteData;
         if (st_presc)   presc_reg   <= bus.WriteData[PRESC_W-1:0];
         // a match in the same cycle wins over any clear request
         if (set_pending) begin
            pending_reg <= 1'b1;
         end else if (clr_pending) begin
            pending_reg <= 1'b0;
         end
      end
   end

   always_comb begin
      read_mux = '0;
      case (offset)
         OFF_CTRL:    read_mux = {29'd0, ctrl_reg};
         OFF_COUNT:   read_mux = count_reg;
         OFF_COMPARE: read_mux = compare_reg;
         OFF_STATUS:  read_mux = {31'd0, pending_reg};
         OFF_PRESC:   read_mux = 32'(presc_reg);
         default:     read_mux = '0;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         read_data_reg <= '0;
         hit_reg       <= 1'b0;
      end else begin
         read_data_reg <= in_win ? read_mux : 32'd0;
         hit_reg       <= in_win;
      end
   end

   assign bus.ReadData = read_data_reg;
   assign bus.hit      = hit_reg;
   assign bus.irq      = pending_reg && ctrl_reg[CTRL_IRQ_EN];
endmodule

// File: tb/tb_mmio_timer.sv
// Self-checking bench for mmio_timer; honours TIMER_AUTORELOAD_EN like the RTL.
module tb_mmio_timer;
   localparam logic [31:0] A_CTRL    = 32'h0000_0400;
   localparam logic [31:0] A_COUNT   = 32'h0000_0404;
   localparam logic [31:0] A_COMPARE = 32'h0000_0408;
   localparam logic [31:0] A_STATUS  = 32'h0000_040C;
   localparam logic [31:0] A_PRESC   = 32'h0000_0410;
`ifdef TIMER_AUTORELOAD_EN
   localparam logic [2:0] CTRL_MASK = 3'b111;
`else
   localparam logic [2:0] CTRL_MASK = 3'b011;
`endif

   logic clock = 1'b0;
   logic reset = 1'b0;
   int   checks = 0;
   int   failures = 0;

   // Expected register contents, kept from what the bench has stored
   logic [31:0] m_count   = 32'd0;
   logic [31:0] m_compare = 32'hFFFF_FFFF;
   logic [31:0] m_presc   = 32'd0;
   logic [2:0]  m_ctrl    = 3'd0;

   mmio_timer_if bus();

   mmio_timer #(.BASE_ADDR(32'h0000_0400), .PRESC_W(16)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic wr_reg(input logic [31:0] a, input logic [31:0] d);
      bus.Address = a; bus.wr = 1'b1; bus.WriteData = d;
      cyc();
      bus.wr = 1'b0; bus.Address = 32'h0;
      $display("wr  addr=%h data=%h", a, d);
   endtask

   task automatic rd_reg(input logic [31:0] a, output logic [31:0] d, output logic h);
      bus.Address = a; bus.wr = 1'b0;
      cyc();
      d = bus.ReadData; h = bus.hit; bus.Address = 32'h0;
      $display("rd  addr=%h data=%h hit=%0b", a, d, h);
   endtask

   task automatic pulse_ack();
      bus.irq_ack = 1'b1;
      cyc();
      bus.irq_ack = 1'b0;
   endtask

   // Cycles from the enabling store edge to the first edge with irq high; -1 on timeout
   task automatic wait_irq(input int budget, output int n);
      n = -1;
      for (int i = 1; i <= budget; i++) begin
         cyc();
         if (bus.irq === 1'b1) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic arm(input int p, input int c, input int k);
      wr_reg(A_CTRL, 32'd0);
      wr_reg(A_STATUS, 32'd1);
      wr_reg(A_PRESC, 32'(p));
      wr_reg(A_COMPARE, 32'(c));
      wr_reg(A_COUNT, 32'(k));
      m_ctrl = 3'd0; m_presc = 32'(p); m_compare = 32'(c); m_count = 32'(k);
   endtask

   task automatic test_reset();
      logic [31:0] d; logic h;
      #1 reset = 1'b1;
      #1;
      checks++; if (bus.ReadData !== 32'd0) begin failures++; $display("FAIL reset_rdata got=%h exp=%h", bus.ReadData, 32'd0); end
      checks++; if (bus.hit !== 1'b0) begin failures++; $display("FAIL reset_hit got=%b exp=0", bus.hit); end
      checks++; if (bus.irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", bus.irq); end
      cyc(); cyc();
      reset = 1'b0;
      rd_reg(A_COMPARE, d, h);
      checks++; if (d !== 32'hFFFF_FFFF) begin failures++; $display("FAIL reset_compare got=%h exp=%h", d, 32'hFFFF_FFFF); end
      checks++; if (h !== 1'b1) begin failures++; $display("FAIL reset_compare_hit got=%b exp=1", h); end
   endtask

   task automatic test_oneshot();
      logic [31:0] d; logic h; int n;
      arm(0, 5, 0);
      wr_reg(A_CTRL, 32'd3);
      wait_irq(100, n);
      checks++; if (n != (5 - 0 + 1) * (0 + 1)) begin failures++; $display("FAIL oneshot_latency got=%0d exp=%0d", n, 6); end
      repeat (5) cyc();
      rd_reg(A_COUNT, d, h);
      checks++; if (d !== 32'd5) begin failures++; $display("FAIL oneshot_count_frozen got=%h exp=%h", d, 32'd5); end
      checks++; if (bus.irq !== 1'b1) begin failures++; $display("FAIL oneshot_irq_held got=%b exp=1", bus.irq); end
      pulse_ack();
      checks++; if (bus.irq !== 1'b0) begin failures++; $display("FAIL oneshot_ack got=%b exp=0", bus.irq); end
      repeat (8) cyc();
      checks++; if (bus.irq !== 1'b0) begin failures++; $display("FAIL oneshot_no_rearm got=%b exp=0", bus.irq); end
   endtask

   task automatic test_prescale();
      int n;
      arm(3, 2, 0);
      wr_reg(A_CTRL, 32'd3);
      wait_irq(200, n);
      checks++; if (n != (2 + 1) * (3 + 1)) begin failures++; $display("FAIL prescale_latency got=%0d exp=%0d", n, 12); end
      pulse_ack();
   endtask

   task automatic test_autoreload();
      logic [31:0] d; logic h; int n;
      logic [31:0] seq [4];
      arm(0, 1, 0);
      wr_reg(A_CTRL, 32'd7);
      m_ctrl = 3'd7 & CTRL_MASK;
      wait_irq(100, n);
      checks++; if (n != 2) begin failures++; $display("FAIL auto_first_match got=%0d exp=2", n); end
`ifdef TIMER_AUTORELOAD_EN
      for (int i = 0; i < 4; i++) begin
         rd_reg(A_COUNT, d, h);
         seq[i] = d;
      end
      for (int i = 0; i < 4; i++) begin
         checks++; if (seq[i] !== 32'(i % 2)) begin failures++; $display("FAIL auto_count_seq[%0d] got=%h exp=%h", i, seq[i], 32'(i % 2)); end
      end
      pulse_ack();
      checks++; if (bus.irq !== 1'b0) begin failures++; $display("FAIL auto_ack got=%b exp=0", bus.irq); end
      wait_irq(10, n);
      checks++; if (n != 1) begin failures++; $display("FAIL auto_rematch got=%0d exp=1", n); end
`else
      seq[0] = 32'd1;
      repeat (4) cyc();
      rd_reg(A_COUNT, d, h);
      checks++; if (d !== seq[0]) begin failures++; $display("FAIL auto_disabled_frozen got=%h exp=%h", d, seq[0]); end
`endif
      rd_reg(A_CTRL, d, h);
      checks++; if (d !== {29'd0, m_ctrl}) begin failures++; $display("FAIL auto_ctrl_read got=%h exp=%h", d, {29'd0, m_ctrl}); end
      wr_reg(A_CTRL, 32'd0);
      pulse_ack();
   endtask

   task automatic test_priority();
      logic [31:0] d; logic h;
      arm(0, 1000, 0);
      wr_reg(A_CTRL, 32'd1);
      repeat (3) cyc();
      wr_reg(A_COUNT, 32'd100);
      rd_reg(A_COUNT, d, h);
      checks++; if (d !== 32'd100) begin failures++; $display("FAIL store_beats_tick got=%h exp=%h", d, 32'd100); end
      arm(0, 10, 10);
      wr_reg(A_CTRL, 32'd3);
      wr_reg(A_STATUS, 32'd1);
      checks++; if (bus.irq !== 1'b1) begin failures++; $display("FAIL set_beats_clear_irq got=%b exp=1", bus.irq); end
      rd_reg(A_STATUS, d, h);
      checks++; if (d !== 32'd1) begin failures++; $display("FAIL set_beats_clear_status got=%h exp=%h", d, 32'd1); end
      wr_reg(A_STATUS, 32'd1);
      rd_reg(A_STATUS, d, h);
      checks++; if (d !== 32'd0) begin failures++; $display("FAIL status_w1c got=%h exp=%h", d, 32'd0); end
      checks++; if (bus.irq !== 1'b0) begin failures++; $display("FAIL status_w1c_irq got=%b exp=0", bus.irq); end
   endtask

   task automatic test_decode();
      logic [31:0] d; logic h;
      arm(2, 77, 33);
      wr_reg(32'h0000_03FC, $urandom);
      wr_reg(32'h0000_0420, $urandom);
      wr_reg(32'h0000_0418, $urandom);
      rd_reg(32'h0000_0414, d, h);
      checks++; if (d !== 32'd0 || h !== 1'b1) begin failures++; $display("FAIL dec_reserved got=%h/%b exp=%h/1", d, h, 32'd0); end
      rd_reg(32'h0000_0418, d, h);
      checks++; if (d !== 32'd0 || h !== 1'b1) begin failures++; $display("FAIL dec_reserved_wr got=%h/%b exp=%h/1", d, h, 32'd0); end
      rd_reg(32'h0000_0420, d, h);
      checks++; if (d !== 32'd0 || h !== 1'b0) begin failures++; $display("FAIL dec_outside got=%h/%b exp=%h/0", d, h, 32'd0); end
      rd_reg(32'h0000_040A, d, h);
      checks++; if (d !== m_compare || h !== 1'b1) begin failures++; $display("FAIL dec_byte_lanes got=%h/%b exp=%h/1", d, h, m_compare); end
      rd_reg(A_COUNT, d, h);
      checks++; if (d !== m_count) begin failures++; $display("FAIL dec_count got=%h exp=%h", d, m_count); end
      rd_reg(A_PRESC, d, h);
      checks++; if (d !== m_presc) begin failures++; $display("FAIL dec_presc got=%h exp=%h", d, m_presc); end
      rd_reg(A_CTRL, d, h);
      checks++; if (d !== {29'd0, m_ctrl}) begin failures++; $display("FAIL dec_ctrl got=%h exp=%h", d, {29'd0, m_ctrl}); end
   endtask

   task automatic test_random();
      logic [31:0] d, r; logic h; int n, p, c, k;
      for (int it = 0; it < 8; it++) begin
         wr_reg(A_CTRL, 32'd0);
         r = $urandom;
         wr_reg(A_PRESC, r);
         rd_reg(A_PRESC, d, h);
         checks++; if (d !== (r & 32'h0000_FFFF)) begin failures++; $display("FAIL rnd_presc[%0d] got=%h exp=%h", it, d, r & 32'h0000_FFFF); end
         r = $urandom;
         r[0] = 1'b0;
         wr_reg(A_CTRL, r);
         rd_reg(A_CTRL, d, h);
         checks++; if (d !== {29'd0, r[2:0] & CTRL_MASK}) begin failures++; $display("FAIL rnd_ctrl[%0d] got=%h exp=%h", it, d, {29'd0, r[2:0] & CTRL_MASK}); end
         p = int'($urandom_range(0, 3));
         c = int'($urandom_range(0, 6));
         k = int'($urandom_range(0, c));
         arm(p, c, k);
         rd_reg(A_COMPARE, d, h);
         checks++; if (d !== m_compare) begin failures++; $display("FAIL rnd_compare[%0d] got=%h exp=%h", it, d, m_compare); end
         wr_reg(A_CTRL, 32'd3);
         wait_irq(200, n);
         checks++; if (n != (c - k + 1) * (p + 1)) begin failures++; $display("FAIL rnd_latency[%0d] p=%0d c=%0d k=%0d got=%0d exp=%0d", it, p, c, k, n, (c - k + 1) * (p + 1)); end
         rd_reg(A_COUNT, d, h);
         checks++; if (d !== 32'(c)) begin failures++; $display("FAIL rnd_count[%0d] got=%h exp=%h", it, d, 32'(c)); end
         pulse_ack();
         checks++; if (bus.irq !== 1'b0) begin failures++; $display("FAIL rnd_ack[%0d] got=%b exp=0", it, bus.irq); end
      end
   endtask

   task automatic test_reset_midcount();
      logic [31:0] d; logic h; int n;
      arm(0, 3, 0);
      wr_reg(A_CTRL, 32'd3);
      wait_irq(50, n);
      checks++; if (n != 4) begin failures++; $display("FAIL mid_latency got=%0d exp=4", n); end
      #3 reset = 1'b1;
      #1;
      checks++; if (bus.irq !== 1'b0) begin failures++; $display("FAIL mid_irq_async got=%b exp=0", bus.irq); end
      cyc();
      reset = 1'b0;
      m_ctrl = 3'd0; m_count = 32'd0; m_compare = 32'hFFFF_FFFF; m_presc = 32'd0;
      rd_reg(A_COMPARE, d, h);
      checks++; if (d !== m_compare) begin failures++; $display("FAIL mid_compare got=%h exp=%h", d, m_compare); end
      rd_reg(A_COUNT, d, h);
      checks++; if (d !== m_count) begin failures++; $display("FAIL mid_count got=%h exp=%h", d, m_count); end
      rd_reg(A_STATUS, d, h);
      checks++; if (d !== 32'd0) begin failures++; $display("FAIL mid_status got=%h exp=%h", d, 32'd0); end
   endtask

   initial begin
      bus.Address = 32'h0; bus.wr = 1'b0; bus.WriteData = 32'h0; bus.irq_ack = 1'b0;
      test_reset();
      test_oneshot();
      test_prescale();
      test_autoreload();
      test_priority();
      test_decode();
      test_random();
      test_reset_midcount();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
